// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_share_arbiter_pkg: ALU control codes and shared defaults        |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package alu_share_arbiter_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CTR_W_DEF = 3;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_ADDU    = 3'b001;
    localparam logic [2:0] ALU_OR      = 3'b010;
    localparam logic [2:0] ALU_ILLEGAL = 3'b011;
    localparam logic [2:0] ALU_SUB     = 3'b100;
    localparam logic [2:0] ALU_SUBU    = 3'b101;
    localparam logic [2:0] ALU_SLT     = 3'b110;
    localparam logic [2:0] ALU_SLTU    = 3'b111;

    function automatic logic is_illegal(input logic [2:0] ctr);
        return ctr == ALU_ILLEGAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb2: two-way round-robin grant with a registered pointer        |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rr_arb2 (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1,
    output logic grant_id
);

    logic r_ptr;

    always_comb begin
        grant0   = enable && valid0 && (!valid1 || !r_ptr);
        grant1   = enable && valid1 && (!valid0 ||  r_ptr);
        grant_id = grant1;
    end

    // Pointer only moves on contention, so a lone requester never steals priority.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr <= 1'b0;
        end else if (enable && valid0 && valid1) begin
            r_ptr <= ~grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_share_arbiter: shares one ALU between two requesters, 1-deep rsp |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CTR_W = CTR_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [CTR_W-1:0] req0_ctr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [CTR_W-1:0] req1_ctr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [CTR_W-1:0] alu_ctr,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic             r_id;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;

    logic             w_can_accept;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_grant_id;
    logic             w_grant_any;
    logic             w_illegal;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [CTR_W-1:0] w_sel_ctr;

    // Gating with resetn keeps both readys low during a reset cycle.
    assign w_can_accept = resetn && ((r_state == ST_EMPTY) || rsp_ready);

    rr_arb2 u_arb (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (w_can_accept),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .grant0   (w_grant0),
        .grant1   (w_grant1),
        .grant_id (w_grant_id)
    );

    assign w_grant_any = w_grant0 || w_grant1;
    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_ctr = '0;
        if (w_grant0) begin
            w_sel_a   = req0_a;
            w_sel_b   = req0_b;
            w_sel_ctr = req0_ctr;
        end else if (w_grant1) begin
            w_sel_a   = req1_a;
            w_sel_b   = req1_b;
            w_sel_ctr = req1_ctr;
        end
        w_illegal = w_grant_any && is_illegal(3'(w_sel_ctr));
    end

    // Illegal codes are replaced so the ALU never sees an undefined control.
    assign alu_a   = w_sel_a;
    assign alu_b   = w_sel_b;
    assign alu_ctr = w_illegal ? CTR_W'(ALU_ADD) : w_sel_ctr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_EMPTY;
            r_id     <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_can_accept) begin
            if (w_grant_any) begin
                r_state  <= ST_FULL;
                r_id     <= w_grant_id;
                r_result <= w_illegal ? '0 : alu_result;
                r_zero   <= w_illegal ? 1'b1 : alu_zero;
                r_err    <= w_illegal;
            end else begin
                r_state  <= ST_EMPTY;
            end
        end
    end

    assign rsp_valid  = (r_state == ST_FULL);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;

endmodule
`default_nettype wire
